adventure_sequencer: RTL and testbench

Command sequencer for the adventure-game core. It buffers scripted move commands in a small FIFO and issues each one to the game as a single-cycle one-hot direction pulse. It samples the game's `win`/`die` after every move and, on a death, resets the game and retries up to a fixed limit. It sits between a command source (testbench script or keypad decoder) and the game core, and owns the core's reset line.

---
 rtl/adventure_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_adventure_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adventure_sequencer.sv
// ---------------------------------------------------------------------------
// adventure_sequencer
//   Buffers scripted move commands in a small FIFO and issues each one to the
//   adventure-game core as a single-cycle one-hot direction pulse. After every
//   step it samples the game's win/die; on a death it resets the game core and
//   retries until MAXTRIES deaths have occurred.
//
// Parameters
//   DEPTH     command FIFO entries (power of two, >= 2)
//   MAXTRIES  deaths allowed before a permanent loss (1..3)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   cmd_valid    in   a command is offered
//   cmd_dir      in   direction: 00=N, 01=S, 10=E, 11=W
//   cmd_ready    out  command accepted when cmd_valid && cmd_ready at an edge
//   game_reset   out  reset line of the game core
//   n, s, e, w   out  one-hot step pulse to the game core
//   win, die     in   status from the game core
//   busy         out  step in flight, restart in progress, or FIFO non-empty
//   won, lost    out  terminal status
//   tries        out  deaths so far
//   moves        out  steps issued since the last restart, saturating at 255
// ---------------------------------------------------------------------------
module adventure_sequencer #(
    parameter int DEPTH    = 4,
    parameter int MAXTRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    output logic       cmd_ready,
    output logic       game_reset,
    output logic       n,
    output logic       s,
    output logic       e,
    output logic       w,
    input  logic       win,
    input  logic       die,
    output logic       busy,
    output logic       won,
    output logic       lost,
    output logic [1:0] tries,
    output logic [7:0] moves
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_RESTART = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_STEP    = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_WON     = 3'd4;
    localparam logic [2:0] S_LOST    = 3'd5;

    localparam logic [1:0]    MAX_TRIES_C = 2'(MAXTRIES);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C       = CW'(1);
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);

    logic [2:0]    r_state;
    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_dir_oh;      // bit index = direction code (N,S,E,W)
    logic          r_game_reset;
    logic          r_won;
    logic          r_lost;
    logic [1:0]    r_tries;
    logic [7:0]    r_moves;

    logic [2:0] w_next;
    logic       w_push;
    logic       w_pop;
    logic       w_death;
    logic [1:0] w_tries_inc;
    logic       w_accepting;

    assign w_accepting = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_CHECK);
    // Decoded from state and count only, so a full FIFO stays not-ready even
    // in the cycle that pops.
    assign cmd_ready   = w_accepting && (r_count < DEPTH_C);
    assign busy        = (r_state == S_RESTART) || (r_state == S_STEP) ||
                         (r_state == S_CHECK)   || (r_count != '0);
    assign w_push      = cmd_valid && cmd_ready;
    assign w_tries_inc = r_tries + 2'd1;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_next  = r_state;
        w_pop   = 1'b0;
        w_death = 1'b0;
        case (r_state)
            S_RESTART: w_next = S_RUN;
            S_RUN: begin
                if (win) begin
                    w_next = S_WON;
                end else if (die) begin
                    w_death = 1'b1;
                end else if (r_count != '0) begin
                    w_pop  = 1'b1;
                    w_next = S_STEP;
                end
            end
            S_STEP: w_next = S_CHECK;
            S_CHECK: begin
                if (win) begin
                    w_next = S_WON;
                end else if (die) begin
                    w_death = 1'b1;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_WON, S_LOST: w_next = r_state;
            default: w_next = S_RESTART;
        endcase
        // win has already taken priority above, so w_death implies !win.
        if (w_death) begin
            w_next = (w_tries_inc == MAX_TRIES_C) ? S_LOST : S_RESTART;
        end
    end

    // NOTE: the FIFO storage has no reset; validity is tracked entirely by
    // the pointers and count, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_dir;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_RESTART;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dir_oh     <= 4'b0000;
            r_game_reset <= 1'b1;
            r_won        <= 1'b0;
            r_lost       <= 1'b0;
            r_tries      <= 2'd0;
            r_moves      <= 8'd0;
        end else begin
            r_state <= w_next;

            // RESTART flushes the FIFO; no push can land in that cycle.
            if (r_state == S_RESTART) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE_C;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE_C;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + ONE_C;
                    2'b01:   r_count <= r_count - ONE_C;
                    default: r_count <= r_count;
                endcase
            end

            if (w_death) begin
                r_tries <= w_tries_inc;
            end

            if (w_next == S_RESTART) begin
                r_moves <= 8'd0;
            end else if ((r_state == S_STEP) && (r_moves != 8'hFF)) begin
                r_moves <= r_moves + 8'd1;
            end

            // Outputs are registered from the next state so each one is
            // valid for exactly the cycles spent in the matching state.
            r_dir_oh     <= w_pop ? (4'b0001 << r_mem[r_rd_ptr]) : 4'b0000;
            r_game_reset <= (w_next == S_RESTART);
            r_won        <= (w_next == S_WON);
            r_lost       <= (w_next == S_LOST);
        end
    end

    assign n          = r_dir_oh[0];
    assign s          = r_dir_oh[1];
    assign e          = r_dir_oh[2];
    assign w          = r_dir_oh[3];
    assign game_reset = r_game_reset;
    assign won        = r_won;
    assign lost       = r_lost;
    assign tries      = r_tries;
    assign moves      = r_moves;

endmodule

// File: tb/tb_adventure_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adventure_sequencer
//   Directed bench for adventure_sequencer. Each issued command pushes its
//   expected one-hot pulse and move count into a scoreboard queue; a monitor
//   pops and compares whenever the sequencer drives a direction pulse. A small
//   game model counts steps since game_reset and raises win/die at
//   programmed step counts.
// ---------------------------------------------------------------------------
module tb_adventure_sequencer;

    localparam int WAIT_WON  = 0;
    localparam int WAIT_LOST = 1;
    localparam int WAIT_GRST = 2;
    localparam int WAIT_IDLE = 3;

    localparam logic [1:0] D_N = 2'b00;
    localparam logic [1:0] D_S = 2'b01;
    localparam logic [1:0] D_E = 2'b10;
    localparam logic [1:0] D_W = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ready;
    logic       game_reset;
    logic       n, s, e, w;
    logic       win, die;
    logic       busy, won, lost;
    logic [1:0] tries;
    logic [7:0] moves;

    typedef struct {
        logic [3:0] oh;
        logic [7:0] mv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    bit have_last = 1'b0;

    int g_steps = 0;
    int win_at  = 0;
    int die_at  = 0;

    adventure_sequencer #(.DEPTH(4), .MAXTRIES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .game_reset (game_reset),
        .n          (n),
        .s          (s),
        .e          (e),
        .w          (w),
        .win        (win),
        .die        (die),
        .busy       (busy),
        .won        (won),
        .lost       (lost),
        .tries      (tries),
        .moves      (moves)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Game model: counts steps since its reset.
    always @(posedge clk) begin
        if (game_reset) g_steps <= 0;
        else if (n | s | e | w) g_steps <= g_steps + 1;
    end
    assign win = (win_at != 0) && (g_steps >= win_at);
    assign die = (die_at != 0) && (g_steps == die_at);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_step(input logic [1:0] d, input logic [7:0] mv);
        exp_t x;
        x.oh = 4'b0001 << d;
        x.mv = mv;
        sb.push_back(x);
    endtask

    // Monitor: compares each observed step pulse with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && (n | s | e | w)) begin
            if (sb.size() == 0) begin
                check("unexpected_step", 32'({w, e, s, n}), 32'd0);
            end else begin
                mon_x = sb.pop_front();
                check("step_dir", 32'({w, e, s, n}), 32'(mon_x.oh));
                check("step_moves", 32'(moves), 32'(mon_x.mv));
                if (have_last) check("step_gap_ge3", 32'(cyc - last_cyc >= 3), 32'd1);
                last_cyc  = cyc;
                have_last = 1'b1;
            end
        end
    end

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic push_cmd(input logic [1:0] d, output bit ok);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        ok        = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_for(input string nm, input int which, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (which)
                WAIT_WON:  hit = won;
                WAIT_LOST: hit = lost;
                WAIT_GRST: hit = game_reset;
                default:   hit = cmd_ready && !busy;
            endcase
            if (hit) break;
            @(posedge clk); #1;
        end
        check(nm, 32'(hit), 32'd1);
    endtask

    // Leaves the bench #1 into the first RUN cycle.
    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        win_at    = 0;
        die_at    = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        bit any_gr;
        bit any_dir;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 2'b00;

        // Reset check
        repeat (2) @(posedge clk);
        #1;
        check("rst_game_reset", 32'(game_reset), 32'd1);
        check("rst_dirs", 32'({w, e, s, n}), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_won_lost", 32'({won, lost}), 32'd0);
        check("rst_tries", 32'(tries), 32'd0);
        check("rst_moves", 32'(moves), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("restart_game_reset", 32'(game_reset), 32'd1);
        check("restart_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("run_game_reset", 32'(game_reset), 32'd0);
        check("run_cmd_ready", 32'(cmd_ready), 32'd1);
        check("run_busy", 32'(busy), 32'd0);

        // Winning script: W, N, N with win after the third step
        win_at = 3;
        expect_step(D_W, 8'd0);
        expect_step(D_N, 8'd1);
        expect_step(D_N, 8'd2);
        push_cmd(D_W, ok); check("win_acc0", 32'(ok), 32'd1);
        push_cmd(D_N, ok); check("win_acc1", 32'(ok), 32'd1);
        push_cmd(D_N, ok); check("win_acc2", 32'(ok), 32'd1);
        wait_for("win_reached", WAIT_WON, 40);
        check("win_moves", 32'(moves), 32'd3);
        check("win_cmd_ready", 32'(cmd_ready), 32'd0);
        check("win_lost", 32'(lost), 32'd0);
        check("win_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("win_held", 32'(won), 32'd1);

        // Fill and stall: prime N, then E,S,W,N,S fill the FIFO to 4
        do_reset();
        expect_step(D_N, 8'd0);
        expect_step(D_E, 8'd1);
        expect_step(D_S, 8'd2);
        expect_step(D_W, 8'd3);
        expect_step(D_N, 8'd4);
        expect_step(D_S, 8'd5);
        expect_step(D_W, 8'd6);
        push_cmd(D_N, ok); check("fill_acc0", 32'(ok), 32'd1);
        push_cmd(D_E, ok); check("fill_acc1", 32'(ok), 32'd1);
        push_cmd(D_S, ok); check("fill_acc2", 32'(ok), 32'd1);
        push_cmd(D_W, ok); check("fill_acc3", 32'(ok), 32'd1);
        push_cmd(D_N, ok); check("fill_acc4", 32'(ok), 32'd1);
        push_cmd(D_S, ok); check("fill_acc5", 32'(ok), 32'd1);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b1;
        cmd_dir   = D_W;
        @(posedge clk); #1;
        check("full_pop_cycle_cmd_ready", 32'(cmd_ready), 32'd0);
        push_cmd(D_W, ok); check("fill_acc_after_full", 32'(ok), 32'd1);
        wait_for("fill_drained", WAIT_IDLE, 60);
        check("fill_moves", 32'(moves), 32'd7);

        // Death and retry: die after the second step
        do_reset();
        die_at = 2;
        expect_step(D_S, 8'd0);
        expect_step(D_E, 8'd1);
        push_cmd(D_S, ok); check("die_acc0", 32'(ok), 32'd1);
        push_cmd(D_E, ok); check("die_acc1", 32'(ok), 32'd1);
        push_cmd(D_N, ok); check("die_acc2", 32'(ok), 32'd1);
        wait_for("die_game_reset", WAIT_GRST, 30);
        check("die_tries", 32'(tries), 32'd1);
        check("die_moves", 32'(moves), 32'd0);
        check("die_restart_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("retry_game_reset_pulse", 32'(game_reset), 32'd0);
        check("retry_cmd_ready", 32'(cmd_ready), 32'd1);
        check("retry_fifo_flushed", 32'(busy), 32'd0);
        expect_step(D_W, 8'd0);
        push_cmd(D_W, ok); check("retry_acc", 32'(ok), 32'd1);
        wait_for("retry_idle", WAIT_IDLE, 30);
        check("retry_moves", 32'(moves), 32'd1);
        check("retry_tries", 32'(tries), 32'd1);

        // Asynchronous reset in the middle of STEP (tries is 1 here)
        push_cmd(D_W, ok); check("async_acc0", 32'(ok), 32'd1);
        push_cmd(D_S, ok); check("async_acc1", 32'(ok), 32'd1);
        check("async_step_w", 32'({w, e, s, n}), 32'b1000);
        #1;
        reset = 1'b1;
        #1;
        check("async_dirs_drop", 32'({w, e, s, n}), 32'd0);
        check("async_tries_clear", 32'(tries), 32'd0);
        check("async_game_reset", 32'(game_reset), 32'd1);
        check("async_cmd_ready", 32'(cmd_ready), 32'd0);
        do_reset();
        check("async_fifo_empty", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Permanent loss: one step per life, dying each time
        do_reset();
        die_at = 1;
        for (int k = 1; k <= 3; k++) begin
            expect_step(D_N, 8'd0);
            push_cmd(D_N, ok); check("loss_acc", 32'(ok), 32'd1);
            if (k < 3) begin
                wait_for("loss_game_reset", WAIT_GRST, 30);
                check("loss_tries_mid", 32'(tries), 32'(k));
            end
        end
        wait_for("loss_reached", WAIT_LOST, 30);
        check("loss_tries", 32'(tries), 32'd3);
        check("loss_won", 32'(won), 32'd0);
        check("loss_cmd_ready", 32'(cmd_ready), 32'd0);
        any_gr  = 1'b0;
        any_dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            any_gr  = any_gr | game_reset;
            any_dir = any_dir | n | s | e | w;
            @(posedge clk); #1;
        end
        check("loss_no_game_reset", 32'(any_gr), 32'd0);
        check("loss_no_dirs", 32'(any_dir), 32'd0);
        check("loss_held", 32'(lost), 32'd1);

        // Simultaneous win and die in CHECK: win has priority
        do_reset();
        win_at = 1;
        die_at = 1;
        expect_step(D_E, 8'd0);
        push_cmd(D_E, ok); check("both_acc", 32'(ok), 32'd1);
        wait_for("both_won", WAIT_WON, 30);
        check("both_tries", 32'(tries), 32'd0);
        check("both_lost", 32'(lost), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
